axi_lite_slave_mem: RTL and testbench

Parametrised AXI4-Lite slave with byte-addressable word storage. It is the next generation of the control-slave top, generalised in data width, depth and base-address window. It adds independent AW/W acceptance, WSTRB byte enables, split decode responses (DECERR/SLVERR) and a saturating error counter. It sits behind the interconnect as a memory-mapped register/scratch window.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_bytemem.sv | 35 +++
 rtl/axi_lite_slave_mem.sv | 150 +++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response encodings and elaboration-time helpers.
package axi_lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_bytemem.sv
// Word storage with one byte-enabled write port and a combinational read port.
// A read on the same edge as a write sees the pre-edge contents.
module axi_lite_bytemem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    widx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [IDX_W-1:0]    ridx,
    output logic [DATA_W-1:0]   rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Non-power-of-two depths leave index codes with no backing word.
    assign rdata = (32'(ridx) < 32'(DEPTH)) ? mem[ridx] : '0;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite scratch/register window: independent AW/W capture, WSTRB writes,
// DECERR/SLVERR decode and a saturating count of error responses.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
    parameter int                WIN_BITS  = 12,
    parameter int                CNT_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                axi_awvalid_i,
    input  logic [ADDR_W-1:0]   axi_awaddr_i,
    output logic                axi_awready_o,
    input  logic                axi_wvalid_i,
    input  logic [DATA_W-1:0]   axi_wdata_i,
    input  logic [DATA_W/8-1:0] axi_wstrb_i,
    output logic                axi_wready_o,
    output logic                axi_bvalid_o,
    output logic [1:0]          axi_bresp_o,
    input  logic                axi_bready_i,
    input  logic                axi_arvalid_i,
    input  logic [ADDR_W-1:0]   axi_araddr_i,
    output logic                axi_arready_o,
    output logic                axi_rvalid_o,
    output logic [DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    input  logic                axi_rready_i,
    output logic [CNT_W-1:0]    err_cnt_o
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_LSB = clog2(STRB_W);
    localparam int IDX_W   = (DEPTH > 1) ? clog2(DEPTH) : 1;

    function automatic axi_resp_t decode(input logic [ADDR_W-1:0] addr);
        if (addr[ADDR_W-1:WIN_BITS] != BASE_ADDR[ADDR_W-1:WIN_BITS]) return RESP_DECERR;
        if (32'(addr[WIN_BITS-1:IDX_LSB]) >= 32'(DEPTH)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              bvalid, rvalid;
    axi_resp_t         bresp, rresp;
    logic [DATA_W-1:0] rdata, mem_rdata;
    logic [CNT_W-1:0]  err_cnt;

    logic      aw_hs, w_hs, ar_hs, commit, b_err, r_err;
    axi_resp_t b_dec, ar_dec;

    assign aw_hs  = axi_awvalid_i && !aw_held;
    assign w_hs   = axi_wvalid_i && !w_held;
    // A pending B that is being accepted this edge frees the slot for the next commit.
    assign commit = aw_held && w_held && (!bvalid || axi_bready_i);
    assign b_dec  = decode(aw_addr);
    assign ar_dec = decode(axi_araddr_i);
    assign ar_hs  = axi_arvalid_i && axi_arready_o;
    assign b_err  = commit && (b_dec != RESP_OKAY);
    assign r_err  = ar_hs && (ar_dec != RESP_OKAY);

    axi_lite_bytemem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .we     (commit && (b_dec == RESP_OKAY)),
        .widx   (aw_addr[IDX_LSB +: IDX_W]),
        .wdata  (w_data),
        .wstrb  (w_strb),
        .ridx   (axi_araddr_i[IDX_LSB +: IDX_W]),
        .rdata  (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= axi_awaddr_i;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= axi_wdata_i;
                w_strb <= axi_wstrb_i;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= b_dec;
        end else if (axi_bready_i) begin
            bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_dec;
            rdata  <= (ar_dec == RESP_OKAY) ? mem_rdata : '0;
        end else if (axi_rready_i) begin
            rvalid <= 1'b0;
        end
    end

    logic [CNT_W:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + (CNT_W+1)'(b_err) + (CNT_W+1)'(r_err);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt <= '0;
        else         err_cnt <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    assign axi_awready_o = !aw_held;
    assign axi_wready_o  = !w_held;
    assign axi_arready_o = !rvalid || axi_rready_i;
    assign axi_bvalid_o  = bvalid;
    assign axi_bresp_o   = bresp;
    assign axi_rvalid_o  = rvalid;
    assign axi_rdata_o   = rdata;
    assign axi_rresp_o   = rresp;
    assign err_cnt_o     = err_cnt;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: directed vector table, hand-written corner
// sequences and a randomized run against a word-array reference model.
module tb_axi_lite_slave_mem;

    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  err_cnt;

    always #5 clk = ~clk;

    axi_lite_slave_mem #(.CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr), .axi_awready_o(awready),
        .axi_wvalid_i(wvalid), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wready_o(wready),
        .axi_bvalid_o(bvalid), .axi_bresp_o(bresp), .axi_bready_i(bready),
        .axi_arvalid_i(arvalid), .axi_araddr_i(araddr), .axi_arready_o(arready),
        .axi_rvalid_o(rvalid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rready_i(rready),
        .err_cnt_o(err_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: plain word array, address rules written as arithmetic.
    logic [31:0] mdl [16];
    int          err_mdl;

    function automatic logic [1:0] ref_resp(input logic [31:0] a);
        if ((a >> 12) != 32'h1) return 2'b11;
        if (((a & 32'hFFF) >> 2) >= 16) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_resp(a) != 2'b00) return 32'h0;
        return mdl[(a & 32'hFFF) >> 2];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (ref_resp(a) == 2'b00) begin
            idx = int'((a & 32'hFFF) >> 2);
            for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic note_resp(input logic [1:0] r);
        if (r != 2'b00 && err_mdl < CNT_MAX) err_mdl++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        err_mdl = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        logic aw_hs, w_hs;
        int   n;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bvalid) check("wr_b_timeout", 64'(bvalid), 64'(1));
        resp = bresp;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic hs;
        int   n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            hs = arready;
            tick();
            n++;
            if (hs) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        if (!rvalid) check("rd_r_timeout", 64'(rvalid), 64'(1));
        d = rdata;
        resp = rresp;
        tick();
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int          exp_err;

        rst_n = 1'b0;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; rready = 0;
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_bvalid", 64'(bvalid), 64'(0));
            check("rst_rvalid", 64'(rvalid), 64'(0));
        end
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_bresp", 64'(bresp), 64'(0));
        check("rst_rresp", 64'(rresp), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        rst_n = 1'b1;
        tick();
        check("rel_awready", 64'(awready), 64'(1));
        check("rel_wready", 64'(wready), 64'(1));
        check("rel_arready", 64'(arready), 64'(1));

        // Directed vectors: expectations written out by hand
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,          4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1008, 32'hDEAD_BEEF,  4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1008, 32'h0000_00AA,  4'h1, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,          4'h0, 2'b00, 32'hDEAD_BEAA});
        vecs.push_back('{1'b1, 32'h8000_1008, 32'h0000_00FF,  4'hF, 2'b11, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,          4'h0, 2'b00, 32'hDEAD_BEAA});
        vecs.push_back('{1'b0, 32'h0000_1040, 32'h0,          4'h0, 2'b10, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1004, 32'h1234_5678,  4'h6, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,          4'h0, 2'b00, 32'h0034_5600});
        vecs.push_back('{1'b1, 32'h0000_1004, 32'hFFFF_FFFF,  4'h0, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,          4'h0, 2'b00, 32'h0034_5600});
        vecs.push_back('{1'b1, 32'h0000_103F, 32'hCAFE_F00D,  4'hF, 2'b00, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_103C, 32'h0,          4'h0, 2'b00, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, 32'h0000_2000, 32'h0,          4'h0, 2'b11, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_1FFC, 32'h0000_0001,  4'hF, 2'b10, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,          4'h0, 2'b11, 32'h0});

        exp_err = 0;
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check($sformatf("vec%0d_bresp", i), 64'(r), 64'(vecs[i].resp));
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), 64'(r), 64'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), 64'(d), 64'(vecs[i].rdata));
            end
            if (vecs[i].resp != 2'b00) exp_err++;
            note_resp(vecs[i].resp);
            check($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(exp_err));
        end

        // B latency: handshake edge N, bvalid visible after N+1
        bready = 1'b1;
        awaddr = 32'h1010; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("lat_bvalid_n", 64'(bvalid), 64'(0));
        check("lat_awready_n", 64'(awready), 64'(0));
        check("lat_wready_n", 64'(wready), 64'(0));
        tick();
        check("lat_bvalid_n1", 64'(bvalid), 64'(1));
        check("lat_bresp_n1", 64'(bresp), 64'(0));
        check("lat_ready_back", 64'({awready, wready}), 64'(2'b11));
        tick();
        check("lat_bvalid_done", 64'(bvalid), 64'(0));
        model_write(32'h1010, 32'h0BAD_F00D, 4'hF);

        // Decoupled channels: W ahead of AW, then bready stalls with a second write queued
        bready = 1'b0;
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("dec_wready_held", 64'(wready), 64'(0));
            check("dec_no_b", 64'(bvalid), 64'(0));
            if (i < 2) tick();
        end
        awaddr = 32'h1014; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("dec_aw_taken", 64'(awready), 64'(0));
        check("dec_b_not_yet", 64'(bvalid), 64'(0));
        tick();
        check("dec_commit_b", 64'(bvalid), 64'(1));
        check("dec_commit_wready", 64'(wready), 64'(1));
        model_write(32'h1014, 32'h55, 4'hF);
        awaddr = 32'h9000_0000; awvalid = 1'b1; wdata = 32'h77; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_bvalid", 64'(bvalid), 64'(1));
            check("stall_bresp", 64'(bresp), 64'(0));
            check("stall_held", 64'({awready, wready}), 64'(0));
            if (i < 3) tick();
        end
        bready = 1'b1;
        tick();
        check("replace_bvalid", 64'(bvalid), 64'(1));
        check("replace_bresp", 64'(bresp), 64'(2'b11));
        note_resp(2'b11);
        check("replace_err_cnt", 64'(err_cnt), 64'(err_mdl));
        tick();
        check("replace_done", 64'(bvalid), 64'(0));
        do_read(32'h1014, d, r);
        check("dec_readback", 64'(d), 64'(ref_read(32'h1014)));

        // Same-edge write commit and read of one word: read returns old data
        do_write(32'h1008, 32'h11, 4'hF, r);
        model_write(32'h1008, 32'h11, 4'hF);
        awaddr = 32'h1008; awvalid = 1'b1; wdata = 32'hAA; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h1008; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check("coll_rvalid", 64'(rvalid), 64'(1));
        check("coll_rdata_old", 64'(rdata), 64'(32'h11));
        check("coll_bvalid", 64'(bvalid), 64'(1));
        model_write(32'h1008, 32'hAA, 4'hF);
        tick();
        do_read(32'h1008, d, r);
        check("coll_rdata_new", 64'(d), 64'(32'hAA));

        // Back-to-back AR with rready toggling
        do_write(32'h1000, 32'hA0, 4'hF, r);
        model_write(32'h1000, 32'hA0, 4'hF);
        begin
            logic [31:0] addrs [3];
            logic [31:0] expq [$];
            logic        ar_hs, r_hs;
            int          issued, got;
            addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
            for (int i = 0; i < 3; i++) expq.push_back(ref_read(addrs[i]));
            issued = 0; got = 0;
            araddr = addrs[0]; arvalid = 1'b1;
            for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
                rready = (cyc % 2 == 0);
                #1;
                ar_hs = arvalid && arready;
                r_hs  = rvalid && rready;
                if (r_hs) begin
                    check($sformatf("b2b_beat%0d", got), 64'(rdata), 64'(expq[got]));
                    got++;
                end
                tick();
                if (ar_hs) begin
                    issued++;
                    if (issued < 3) araddr = addrs[issued];
                    else arvalid = 1'b0;
                end
            end
            arvalid = 1'b0;
            rready = 1'b1;
            check("b2b_beats", 64'(got), 64'(3));
            tick();
            check("b2b_no_extra", 64'(rvalid), 64'(0));
        end

        // Reset with only AW held
        awaddr = 32'h1008; awvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_aw_held", 64'(awready), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", 64'(bvalid), 64'(0));
        check("mid_rst_awready", 64'(awready), 64'(1));
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check("mid_rel_awready", 64'(awready), 64'(1));
        check("mid_rel_err_cnt", 64'(err_cnt), 64'(0));
        wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick(); tick();
        check("mid_no_orphan_b", 64'(bvalid), 64'(0));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h1008, d, r);
        check("mid_mem_cleared", 64'(d), 64'(0));

        // Randomized traffic against the model, long enough to saturate err_cnt
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, dv;
            logic [3:0]  s;
            int          k;
            k = int'($urandom_range(0, 9));
            if (k <= 6)      a = 32'h1000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            else if (k <= 8) a = 32'h1000 + ($urandom_range(16, 1023) << 2);
            else begin
                a = $urandom;
                if ((a >> 12) == 32'h1) a = a ^ 32'h8000_0000;
            end
            dv = $urandom;
            s  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, dv, s, r);
                check("rnd_bresp", 64'(r), 64'(ref_resp(a)));
                model_write(a, dv, s);
            end else begin
                do_read(a, d, r);
                check("rnd_rresp", 64'(r), 64'(ref_resp(a)));
                check("rnd_rdata", 64'(d), 64'(ref_read(a)));
            end
            note_resp(ref_resp(a));
            check("rnd_err_cnt", 64'(err_cnt), 64'(err_mdl));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
